// File: rtl/uart_baud_ctrl.sv
// Divisor change sequencer for the UART baud generator: validates a requested divisor,
// waits for TX/RX to go quiet, then loads it while holding the generator in reset.
module uart_baud_ctrl #(
    parameter int unsigned DIV_W       = 24,
    parameter int unsigned DEFAULT_DIV = 434,
    parameter int unsigned MIN_DIV     = 2,
    parameter int unsigned QUIET_CYC   = 4,
    parameter int unsigned GEN_RST_CYC = 2,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [DIV_W-1:0] i_cfg_div,
    input  logic             i_tx_busy,
    input  logic             i_rx_busy,
    output logic [DIV_W-1:0] o_div_num,
    output logic             o_gen_rst,
    output logic             o_cfg_done,
    output logic             o_cfg_err,
    output logic             o_switching
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_QUIET,
        S_APPLY,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_num_q, div_num_d;
    logic [DIV_W-1:0]   div_cap_q, div_cap_d;
    logic [CNT_W-1:0]   quiet_q, quiet_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic               gen_rst_q, gen_rst_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               sw_q, sw_d;
    logic               quiet_c;

    assign quiet_c = !i_tx_busy && !i_rx_busy;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + CNT_W'(1);
    endfunction

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        div_num_d = div_num_q;
        div_cap_d = div_cap_q;
        quiet_d   = quiet_q;
        tmo_d     = tmo_q;
        gen_rst_d = gen_rst_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        sw_d      = sw_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_cfg_valid) begin
                    div_cap_d = i_cfg_div;
                    sw_d      = 1'b1;
                    if (i_cfg_div < DIV_W'(MIN_DIV)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (i_cfg_div == div_num_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT_QUIET;
                        quiet_d = '0;
                        tmo_d   = '0;
                    end
                end
            end

            S_WAIT_QUIET: begin
                tmo_d   = sat_inc(tmo_q);
                quiet_d = quiet_c ? sat_inc(quiet_q) : '0;
                if (quiet_c && (quiet_q == CNT_W'(QUIET_CYC - 1))) begin
                    state_d   = S_APPLY;
                    div_num_d = div_cap_q;
                    gen_rst_d = 1'b1;
                    tmo_d     = '0;
                end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end

            // The timeout counter doubles as the reset-hold counter here.
            S_APPLY: begin
                tmo_d = sat_inc(tmo_q);
                if (tmo_q == CNT_W'(GEN_RST_CYC - 1)) begin
                    state_d   = S_DONE;
                    gen_rst_d = 1'b0;
                    done_d    = 1'b1;
                end
            end

            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                sw_d    = 1'b0;
            end

            default: begin
                state_d   = S_IDLE;
                gen_rst_d = 1'b0;
                sw_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_num_q <= DIV_W'(DEFAULT_DIV);
            div_cap_q <= DIV_W'(DEFAULT_DIV);
            quiet_q   <= '0;
            tmo_q     <= '0;
            gen_rst_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sw_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_num_q <= div_num_d;
            div_cap_q <= div_cap_d;
            quiet_q   <= quiet_d;
            tmo_q     <= tmo_d;
            gen_rst_q <= gen_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
            sw_q      <= sw_d;
        end
    end

    assign o_cfg_ready = (state_q == S_IDLE);
    assign o_div_num   = div_num_q;
    assign o_gen_rst   = gen_rst_q;
    assign o_cfg_done  = done_q;
    assign o_cfg_err   = err_q;
    assign o_switching = sw_q;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Scoreboard bench for uart_baud_ctrl: two instances (default and short timeout) share
// stimulus; a request-level model predicts each outcome, a monitor checks every pulse.
module tb_uart_baud_ctrl;

    localparam int unsigned DW       = 24;
    localparam int unsigned DEF      = 434;
    localparam int unsigned MIN      = 2;
    localparam int unsigned QC       = 4;
    localparam int unsigned GC       = 2;
    localparam int          TMO0     = 65535;
    localparam int          TMO1     = 16;
    localparam int          PAT_MAX  = 64;
    localparam int          WAIT_MAX = 2000;

    typedef struct {
        bit          err;
        int          end_cyc;
        int          rst_start;
        int          rst_len;
        logic [DW-1:0] div;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic i_cfg_valid;
    logic [DW-1:0] i_cfg_div;
    logic i_tx_busy, i_rx_busy;

    logic rdy0, grst0, done0, err0, sw0;
    logic rdy1, grst1, done1, err1, sw1;
    logic [DW-1:0] div0, div1;

    exp_t q0[$];
    exp_t q1[$];
    bit   pat_tx[PAT_MAX];
    bit   pat_rx[PAT_MAX];
    int   plen;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rlen[2];
    int   rstart[2];
    logic [DW-1:0] rdiv[2];
    logic [DW-1:0] cur0, cur1;

    always #5 clock = ~clock;

    uart_baud_ctrl dut0 (
        .clock(clock), .reset(reset),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(rdy0), .i_cfg_div(i_cfg_div),
        .i_tx_busy(i_tx_busy), .i_rx_busy(i_rx_busy),
        .o_div_num(div0), .o_gen_rst(grst0), .o_cfg_done(done0),
        .o_cfg_err(err0), .o_switching(sw0)
    );

    uart_baud_ctrl #(.TIMEOUT(TMO1)) dut1 (
        .clock(clock), .reset(reset),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(rdy1), .i_cfg_div(i_cfg_div),
        .i_tx_busy(i_tx_busy), .i_rx_busy(i_rx_busy),
        .o_div_num(div1), .o_gen_rst(grst1), .o_cfg_done(done1),
        .o_cfg_err(err1), .o_switching(sw1)
    );

    // Request-level prediction: outcome, completion cycle and reset window.
    // Offset k after the accept edge corresponds to monitor cycle cA+k-1.
    function automatic exp_t model(input logic [DW-1:0] d, input logic [DW-1:0] cur,
                                   input int tmo, input int cA);
        exp_t e;
        int   run;
        bit   b;
        e.err = 1'b0; e.end_cyc = cA; e.rst_start = 0; e.rst_len = 0; e.div = cur;
        if (d < DW'(MIN)) begin
            e.err = 1'b1;
            return e;
        end
        if (d == cur) return e;
        run = 0;
        for (int k = 1; k <= tmo; k++) begin
            b = 1'b0;
            if (k <= PAT_MAX) b = pat_tx[k-1] | pat_rx[k-1];
            run = b ? 0 : run + 1;
            if (run == int'(QC)) begin
                e.rst_start = cA + k;
                e.rst_len   = int'(GC);
                e.end_cyc   = cA + k + int'(GC);
                e.div       = d;
                return e;
            end
        end
        e.err     = 1'b1;
        e.end_cyc = cA + tmo;
        return e;
    endfunction

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Per-cycle check of one instance against its queue of outstanding requests.
    task automatic mon(input int i, input logic done, input logic err, input logic grst,
                       input logic rdy, input logic sw, input logic [DW-1:0] div);
        exp_t e;
        int   qs;
        bit   ok;
        qs = (i == 0) ? q0.size() : q1.size();
        checks++;
        if (rdy !== (qs == 0) || sw !== (qs > 0) || (grst === 1'b1 && qs == 0)) begin
            errors++;
            $display("FAIL handshake dut%0d cyc %0d: ready=%b switching=%b gen_rst=%b, outstanding=%0d",
                     i, cyc, rdy, sw, grst, qs);
        end
        if (grst === 1'b1) begin
            if (rlen[i] == 0) begin
                rstart[i] = cyc;
                rdiv[i]   = div;
            end
            rlen[i]++;
        end
        if (done === 1'b1 || err === 1'b1) begin
            checks++;
            if (qs == 0) begin
                errors++;
                $display("FAIL unexpected_pulse dut%0d cyc %0d: done=%b err=%b, expected none",
                         i, cyc, done, err);
            end else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                ok = (err === e.err) && (done === !e.err) && (cyc == e.end_cyc) &&
                     (div === e.div) && (rlen[i] == e.rst_len) &&
                     (rlen[i] == 0 || (rstart[i] == e.rst_start && rdiv[i] === e.div));
                if (!ok) begin
                    errors++;
                    $display("FAIL result dut%0d: got err=%b done=%b cyc=%0d div=%0d rst_len=%0d rst_at=%0d rst_div=%0d, expected err=%b cyc=%0d div=%0d rst_len=%0d rst_at=%0d",
                             i, err, done, cyc, div, rlen[i], rstart[i], rdiv[i],
                             e.err, e.end_cyc, e.div, e.rst_len, e.rst_start);
                end
            end
            rlen[i] = 0;
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        mon(0, done0, err0, grst0, rdy0, sw0, div0);
        mon(1, done1, err1, grst1, rdy1, sw1, div1);
    end

    task automatic clear_pat(input int len);
        for (int k = 0; k < PAT_MAX; k++) begin
            pat_tx[k] = 1'b0;
            pat_rx[k] = 1'b0;
        end
        plen = len;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock); #1;
        while (!(rdy0 && rdy1 && q0.size() == 0 && q1.size() == 0)) begin
            if (n == WAIT_MAX) begin
                checks++;
                errors++;
                $display("FAIL wait_idle: controller still busy after %0d cycles, expected idle", n);
                finish_sim();
            end
            @(negedge clock); #1;
            n++;
        end
    endtask

    // Issue one request, push predictions, then play the busy pattern.
    task automatic run_req(input logic [DW-1:0] d);
        exp_t e;
        bit   sw;
        wait_idle();
        i_cfg_valid = 1'b1;
        i_cfg_div   = d;
        @(posedge clock); #1;
        sw = (d >= DW'(MIN)) && (d != cur0) && (d != cur1);
        e = model(d, cur0, TMO0, cyc + 1); q0.push_back(e); cur0 = e.div;
        e = model(d, cur1, TMO1, cyc + 1); q1.push_back(e); cur1 = e.div;
        i_cfg_valid = 1'b0;
        i_tx_busy   = pat_tx[0];
        i_rx_busy   = pat_rx[0];
        for (int k = 1; k < plen; k++) begin
            @(posedge clock); #1;
            i_tx_busy = pat_tx[k];
            i_rx_busy = pat_rx[k];
            // Both instances are still waiting for quiet here, so a stray valid must be ignored.
            if (sw && k <= 3) begin
                i_cfg_valid = 1'($urandom % 2);
                i_cfg_div   = DW'($urandom);
            end else begin
                i_cfg_valid = 1'b0;
            end
        end
        @(posedge clock); #1;
        i_cfg_valid = 1'b0;
        i_tx_busy   = 1'b0;
        i_rx_busy   = 1'b0;
    endtask

    initial begin
        int n, p, r;
        logic [DW-1:0] d;
        reset = 1'b1; i_cfg_valid = 1'b0; i_cfg_div = '0; i_tx_busy = 1'b0; i_rx_busy = 1'b0;
        cur0 = DW'(DEF); cur1 = DW'(DEF);
        rlen[0] = 0; rlen[1] = 0;
        clear_pat(1);
        repeat (3) @(negedge clock);
        reset = 1'b0;

        for (int c = 0; c < 10; c++) begin
            @(negedge clock); #1;
            chk("idle_div0", 32'(div0), DEF);
            chk("idle_div1", 32'(div1), DEF);
            chk("idle_ready", {30'd0, rdy0, rdy1}, 32'd3);
            chk("idle_gen_rst", {30'd0, grst0, grst1}, 32'd0);
        end

        clear_pat(1); run_req(DW'(868));
        clear_pat(1); run_req(DW'(868));
        clear_pat(1); run_req(DW'(1));
        clear_pat(1); run_req(DW'(0));
        clear_pat(1); run_req(DW'(MIN));

        // Long TX burst, then a one-cycle RX glitch inside the quiet window.
        clear_pat(30);
        for (int k = 0; k < 20; k++) pat_tx[k] = 1'b1;
        pat_rx[22] = 1'b1;
        run_req(DW'(434));

        // RX held busy past the short timeout.
        clear_pat(40);
        for (int k = 0; k < 40; k++) pat_rx[k] = 1'b1;
        run_req(DW'(500));

        // Reset while the generator is being held for a switch.
        clear_pat(1);
        run_req(DW'(1000));
        n = 0;
        while (grst0 !== 1'b1 && n < 20) begin
            @(negedge clock); #1;
            n++;
        end
        chk("reached_apply", 32'(grst0), 32'd1);
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        chk("rst_div0", 32'(div0), DEF);
        chk("rst_div1", 32'(div1), DEF);
        chk("rst_gen_rst", {30'd0, grst0, grst1}, 32'd0);
        chk("rst_pulses", {28'd0, done0, done1, err0, err1}, 32'd0);
        q0.delete(); q1.delete();
        rlen[0] = 0; rlen[1] = 0;
        cur0 = DW'(DEF); cur1 = DW'(DEF);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;

        clear_pat(1); run_req(DW'(2000));

        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(0, 5));
            case (r)
                0:       d = DW'($urandom_range(0, 1));
                1:       d = DW'(MIN);
                2:       d = cur0;
                3:       d = cur1;
                default: d = DW'($urandom_range(MIN, 5000));
            endcase
            clear_pat(int'($urandom_range(1, 40)));
            p = int'($urandom_range(0, 40));
            for (int k = 0; k < plen; k++) begin
                pat_tx[k] = ($urandom_range(0, 99) < p);
                pat_rx[k] = ($urandom_range(0, 99) < p);
            end
            run_req(d);
        end

        wait_idle();
        finish_sim();
    end

endmodule
